// File: rtl/mii_tx_framer_pkg.sv
// Shared constants and state encoding for the MII transmit framer and receive checker.
package mii_tx_framer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StSfd,
    StData,
    StPad,
    StFcs,
    StErr,
    StIpg
  } tx_state_e;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [3:0]  PREAMBLE_NIB    = 4'h5;
  localparam logic [3:0]  SFD_NIB         = 4'hD;

  // Reflected CRC32 advanced by one nibble, bit 0 of the nibble first.
  function automatic logic [31:0] crc32_nib_step(input logic [31:0] crc, input logic [3:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 4; i++) begin
      c = (c[0] ^ d[i]) ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/mii_tx_framer_if.sv
// Byte-stream input handshake plus MII TX pins and status of the framer.
interface mii_tx_framer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       mii_tx_en;
  logic       mii_tx_er;
  logic [3:0] mii_txd;
  logic       busy;
  logic       underrun;

  modport master (
    output tx_data, tx_valid, tx_last,
    input  tx_ready, mii_tx_en, mii_tx_er, mii_txd, busy, underrun
  );

  modport slave (
    input  tx_data, tx_valid, tx_last,
    output tx_ready, mii_tx_en, mii_tx_er, mii_txd, busy, underrun
  );
endinterface

// File: rtl/mii_tx_framer_crc32_nibble.sv
// Nibble-serial Ethernet CRC32 register; init has priority over en.
module crc32_nibble
  import mii_tx_framer_pkg::*;
(
  input  logic        clk,
  input  logic        SW0,
  input  logic        init,
  input  logic        en,
  input  logic [3:0]  d,
  output logic [31:0] crc
);

  logic [31:0] crc_q, crc_d;

  // Next CRC value: reload, advance by one nibble, or hold.
  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = CRC32_INIT;
    end else if (en) begin
      crc_d = crc32_nib_step(crc_q, d);
    end
  end

  // CRC state register.
  always_ff @(posedge clk or posedge SW0) begin
    if (SW0) begin
      crc_q <= CRC32_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/mii_tx_framer.sv
// MII transmit framer: preamble, SFD, payload, zero pad, FCS and inter-packet gap as nibbles.
// All pin outputs are flops loaded from next-state values, so the nibble on mii_txd and the
// state register always describe the same cycle; the CRC advances on the edge that loads
// each payload/pad nibble onto mii_txd.
module mii_tx_framer
  import mii_tx_framer_pkg::*;
#(
  parameter int unsigned MIN_PAYLOAD = 60,
  parameter int unsigned PRE_NIBBLES = 15,
  parameter int unsigned IPG_NIBBLES = 24
) (
  input logic             clk,
  input logic             SW0,
  mii_tx_framer_if.slave  bus
);

  localparam int unsigned CntW   = 5;
  localparam logic [10:0] MinLen = 11'(MIN_PAYLOAD);

  tx_state_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic        hi_q, hi_d;
  logic [7:0]  hold_q, hold_d;
  logic        last_q, last_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [3:0]  txd_q, txd_d;
  logic        tx_en_q, tx_en_d;
  logic        tx_er_q, tx_er_d;
  logic        ready_q, ready_d;
  logic        underrun_q, underrun_d;
  logic        busy_q;

  logic        crc_init, crc_en;
  logic [31:0] crc, fcs;
  logic [10:0] byte_inc;
  logic [2:0]  fcs_sel;

  crc32_nibble u_crc (
    .clk  (clk),
    .SW0  (SW0),
    .init (crc_init),
    .en   (crc_en),
    .d    (txd_d),
    .crc  (crc)
  );

  assign fcs      = ~crc;
  assign fcs_sel  = cnt_q[2:0] + 3'd1;
  assign byte_inc = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;

  // Next state, counters and the values the output flops take at the coming edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    hold_d     = hold_q;
    last_d     = last_q;
    byte_cnt_d = byte_cnt_q;
    txd_d      = 4'h0;
    tx_en_d    = 1'b0;
    tx_er_d    = 1'b0;
    ready_d    = 1'b0;
    underrun_d = 1'b0;
    crc_init   = 1'b0;
    crc_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        crc_init   = 1'b1;
        byte_cnt_d = '0;
        ready_d    = 1'b1;
        if (bus.tx_valid && ready_q) begin
          hold_d  = bus.tx_data;
          last_d  = bus.tx_last;
          state_d = StPre;
          cnt_d   = '0;
          tx_en_d = 1'b1;
          txd_d   = PREAMBLE_NIB;
          ready_d = 1'b0;
        end
      end
      StPre: begin
        tx_en_d = 1'b1;
        if (cnt_q == CntW'(PRE_NIBBLES - 1)) begin
          state_d = StSfd;
          txd_d   = SFD_NIB;
        end else begin
          cnt_d = cnt_q + 1'b1;
          txd_d = PREAMBLE_NIB;
        end
      end
      StSfd: begin
        state_d = StData;
        hi_d    = 1'b0;
        tx_en_d = 1'b1;
        txd_d   = hold_q[3:0];
        crc_en  = 1'b1;
      end
      StData: begin
        tx_en_d = 1'b1;
        if (!hi_q) begin
          hi_d    = 1'b1;
          txd_d   = hold_q[7:4];
          crc_en  = 1'b1;
          ready_d = !last_q;
        end else begin
          byte_cnt_d = byte_inc;
          if (last_q) begin
            if (byte_inc < MinLen) begin
              state_d = StPad;
              hi_d    = 1'b0;
              crc_en  = 1'b1;
            end else begin
              state_d = StFcs;
              cnt_d   = '0;
              txd_d   = fcs[3:0];
            end
          end else if (bus.tx_valid) begin
            hold_d = bus.tx_data;
            last_d = bus.tx_last;
            hi_d   = 1'b0;
            txd_d  = bus.tx_data[3:0];
            crc_en = 1'b1;
          end else begin
            state_d    = StErr;
            underrun_d = 1'b1;
            tx_er_d    = 1'b1;
          end
        end
      end
      StPad: begin
        tx_en_d = 1'b1;
        if (!hi_q) begin
          hi_d   = 1'b1;
          crc_en = 1'b1;
        end else begin
          byte_cnt_d = byte_inc;
          if (byte_inc >= MinLen) begin
            state_d = StFcs;
            cnt_d   = '0;
            txd_d   = fcs[3:0];
          end else begin
            hi_d   = 1'b0;
            crc_en = 1'b1;
          end
        end
      end
      StFcs: begin
        if (cnt_q == CntW'(7)) begin
          state_d = StIpg;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          tx_en_d = 1'b1;
          txd_d   = fcs[{fcs_sel, 2'b00} +: 4];
        end
      end
      StErr: begin
        state_d = StIpg;
        cnt_d   = '0;
      end
      StIpg: begin
        // The IDLE cycle that precedes any new preamble supplies the final gap nibble.
        if (cnt_q == CntW'(IPG_NIBBLES - 2)) begin
          state_d = StIdle;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counters, hold register and registered outputs.
  always_ff @(posedge clk or posedge SW0) begin
    if (SW0) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      hi_q       <= 1'b0;
      hold_q     <= '0;
      last_q     <= 1'b0;
      byte_cnt_q <= '0;
      txd_q      <= '0;
      tx_en_q    <= 1'b0;
      tx_er_q    <= 1'b0;
      ready_q    <= 1'b0;
      underrun_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      hold_q     <= hold_d;
      last_q     <= last_d;
      byte_cnt_q <= byte_cnt_d;
      txd_q      <= txd_d;
      tx_en_q    <= tx_en_d;
      tx_er_q    <= tx_er_d;
      ready_q    <= ready_d;
      underrun_q <= underrun_d;
      busy_q     <= (state_d != StIdle);
    end
  end

  assign bus.tx_ready  = ready_q;
  assign bus.mii_txd   = txd_q;
  assign bus.mii_tx_en = tx_en_q;
  assign bus.mii_tx_er = tx_er_q;
  assign bus.underrun  = underrun_q;
  assign bus.busy      = busy_q;

endmodule
